uart_tx_engine: RTL
===================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter UART_PRESCALE, default 0; PCLK is pre-divided by 2^UART_PRESCALE before the baud divisor.
REQ-002 SHALL have port PCLK, input, 1, clock; one clock domain only.
REQ-003 SHALL have port PRESETn, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port TxData, input, 8, byte to transmit.
REQ-005 SHALL have port TxValid, input, 1, TxData is valid.
REQ-006 SHALL have port TxReady, output, 1, engine can accept a byte (shift register empty).
REQ-007 SHALL have port LCR, input, 7, line control: [1:0] word length, [2] stop bits, [3] PEN, [4] EPS, [5] stick parity, [6] break.
REQ-008 SHALL have port Divisor, input, 16, baud divisor {DLM,DLL}.
REQ-009 SHALL have port SOUT, output, 1, serial output; idle level 1.
REQ-010 SHALL have port TxBusy, output, 1, frame in progress; the inverse of TEMT.
REQ-011 SHALL have port TxDone, output, 1, one-cycle pulse at the end of a frame.

Function
REQ-012 SHALL generate a pre-tick every 2^UART_PRESCALE PCLK cycles using a free-running prescale counter.
REQ-013 SHALL generate baud16 ticks with a divisor counter: one baud16 tick per Divisor pre-ticks; Divisor=0 is treated as 1.
REQ-014 SHALL keep the baud generator free-running, with Divisor sampled live; a Divisor change takes effect when the divisor counter next reloads.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; each bit lasts 16 baud16 ticks, counted by a 4-bit bit-tick counter.
REQ-016 SHALL assert TxReady=1 only in IDLE; acceptance = TxValid & TxReady in the same PCLK cycle.
REQ-017 On acceptance, SHALL capture TxData and LCR[5:0], clear the bit-tick counter, and enter START on the next cycle.
REQ-018 SHALL drive SOUT=0 in START, then DATA bits LSB first; the bit count is 5 + LCR[1:0], using snapshot values.
REQ-019 SHALL enter PARITY after DATA only when the snapshot PEN=1; otherwise it goes directly to STOP.
REQ-020 SHALL drive the parity bit as follows; only the valid data bits enter the XOR:
  - SP=1: parity = ~EPS.
  - SP=0, EPS=1: parity = XOR of the data bits (even parity).
  - SP=0, EPS=0: parity = ~XOR of the data bits (odd parity).
REQ-021 SHALL drive SOUT=1 in STOP; STOP lasts one bit if snapshot LCR[2]=0 and two bits if LCR[2]=1, including for 5-bit words (no 1.5 stop).
REQ-022 On the last baud16 tick of STOP, SHALL pulse TxDone for exactly 1 cycle and return to IDLE in the next cycle.
REQ-023 Back-to-back bytes SHALL have at least one PCLK of IDLE between them.
REQ-024 SHALL ignore LCR[5:0] changes during a frame (snapshot only).
REQ-025 SHALL treat LCR[6] (break) as live: while it is 1, SOUT=0 in every state; frame timing and the state machine are unaffected.
REQ-026 SHALL set TxBusy=1 in every state except IDLE.
REQ-027 SHALL ignore TxValid whenever TxReady=0; no byte is lost or duplicated.
REQ-028 SHALL allow the first bit of a frame to be up to one baud16 period plus one PCLK longer than 16 ticks (generator phase); every later bit SHALL be exactly 16 ticks.

Reset
REQ-029 When PRESETn=0 at a PCLK edge, SHALL enter IDLE and clear all counters.
REQ-030 Outputs in and immediately after reset SHALL be: SOUT=1, TxReady=1, TxBusy=0, TxDone=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with no TxDone pulse; SOUT returns to 1 on the next cycle.
REQ-032 After reset, no state SHALL be retained from the aborted frame.

Verification
REQ-033 SHALL cover 8N1 framing: P=0, Divisor=1, LCR=0x03, send 0x55 -> SOUT = 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; TxDone about 160 cycles after acceptance.
REQ-034 SHALL cover even parity: LCR=0x1A (7-bit, even), send 0x03 -> 7 data bits 1,1,0,0,0,0,0, then parity 0, then 1 stop bit.
REQ-035 SHALL cover stick parity: LCR=0x2B, send 0xFF -> parity bit 1. Then LCR=0x3B, send 0xFF -> parity bit 0.
REQ-036 SHALL cover 5-bit with two stops and divisor scaling:
  - LCR=0x04, Divisor=3, P=1 -> baud16 tick every 6 cycles, bit = 96 cycles.
  - Frame = 8 bits; stop level high for 192 cycles.
REQ-037 SHALL cover break and snapshot:
  - LCR[6] set mid-DATA -> SOUT=0 at once; the frame still ends with TxDone at the nominal time.
  - LCR[1:0] changed mid-frame -> the current frame keeps the captured length.
REQ-038 SHALL cover reset and corner cases:
  - PRESETn low in DATA -> next cycle SOUT=1, TxReady=1, no TxDone.
  - Divisor=0 -> same timing as Divisor=1.
  - TxValid held high -> consecutive frames separated by exactly 1 idle cycle.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 16550-style transmit serializer with a free-running prescaled
// baud16 generator, programmable word length/parity/stop bits and live break.
module uart_tx_engine #(
    parameter int UART_PRESCALE = 0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [7:0]  TxData,
    input  logic        TxValid,
    output logic        TxReady,
    input  logic [6:0]  LCR,
    input  logic [15:0] Divisor,
    output logic        SOUT,
    output logic        TxBusy,
    output logic        TxDone
);
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic              pre_tick;
    logic [15:0]       div_cnt;
    logic [15:0]       div_eff;
    logic              baud_tick;
    logic [3:0]        bit_tick, bit_tick_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [2:0]        last_idx;
    logic              stop_idx, stop_idx_nxt;
    logic              first_tick, first_tick_nxt;
    logic [DATA_W-1:0] data_snap;
    logic [5:0]        lcr_snap;
    logic              accept;
    logic              bit_end;
    logic              sout_frame;

    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [5:0] lcr);
        logic [DATA_W-1:0] mask;
        logic              x;
        mask = 8'hFF >> (2'd3 - lcr[1:0]);
        x    = ^(d & mask);
        if (lcr[5])
            return ~lcr[4];
        else if (lcr[4])
            return x;
        else
            return ~x;
    endfunction

    generate
        if (UART_PRESCALE == 0) begin : g_nopre
            assign pre_tick = 1'b1;
        end else begin : g_pre
            logic [UART_PRESCALE-1:0] pre_cnt;
            always_ff @(posedge PCLK) begin
                if (!PRESETn)
                    pre_cnt <= '0;
                else
                    pre_cnt <= pre_cnt + 1'b1;
            end
            assign pre_tick = &pre_cnt;
        end
    endgenerate

    // Divisor is sampled only at reload, so a change never truncates the current period.
    assign div_eff   = (Divisor == 16'd0) ? 16'd1 : Divisor;
    assign baud_tick = pre_tick && (div_cnt == 16'd0);

    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            div_cnt <= '0;
        else if (pre_tick)
            div_cnt <= (div_cnt == 16'd0) ? (div_eff - 16'd1) : (div_cnt - 16'd1);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= IDLE;
            bit_tick   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            first_tick <= 1'b0;
            lcr_snap   <= '0;
        end else begin
            state      <= state_nxt;
            bit_tick   <= bit_tick_nxt;
            bit_idx    <= bit_idx_nxt;
            stop_idx   <= stop_idx_nxt;
            first_tick <= first_tick_nxt;
            if (accept)
                lcr_snap <= LCR[5:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (accept)
            data_snap <= TxData;
    end

    // The first baud16 tick after acceptance only aligns to the generator phase.
    assign accept   = TxReady && TxValid;
    assign bit_end  = baud_tick && !first_tick && (bit_tick == 4'd15);
    assign last_idx = 3'd4 + {1'b0, lcr_snap[1:0]};

    always_comb begin
        state_nxt      = state;
        bit_tick_nxt   = bit_tick;
        bit_idx_nxt    = bit_idx;
        stop_idx_nxt   = stop_idx;
        first_tick_nxt = first_tick;
        TxReady        = 1'b0;
        TxDone         = 1'b0;
        sout_frame     = 1'b1;

        if (state != IDLE && baud_tick) begin
            if (first_tick)
                first_tick_nxt = 1'b0;
            else
                bit_tick_nxt = bit_tick + 4'd1;
        end

        case (state)
            IDLE: begin
                TxReady = 1'b1;
                if (TxValid) begin
                    state_nxt      = START;
                    bit_tick_nxt   = '0;
                    bit_idx_nxt    = '0;
                    stop_idx_nxt   = 1'b0;
                    first_tick_nxt = 1'b1;
                end
            end
            START: begin
                sout_frame = 1'b0;
                if (bit_end)
                    state_nxt = DATA;
            end
            DATA: begin
                sout_frame = data_snap[bit_idx];
                if (bit_end) begin
                    if (bit_idx == last_idx)
                        state_nxt = lcr_snap[3] ? PARITY : STOP;
                    else
                        bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            PARITY: begin
                sout_frame = parity_bit(data_snap, lcr_snap);
                if (bit_end)
                    state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (lcr_snap[2] && !stop_idx) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        TxDone    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SOUT   = sout_frame & ~LCR[6];
    assign TxBusy = (state != IDLE);

endmodule
